// File: rtl/mem16_pkg.sv
// Shared types and constants for the mem16 bus initiator: data width default and FSM encoding.
package mem16_pkg;

  localparam int MEM16_DW = 16;
  localparam int ST_W     = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_VRD    = 3'd4
  } state_t;

endpackage

// File: rtl/mem16_lat_cnt.sv
// Loadable 4-bit down-counter; done marks the last cycle of the programmed latency.
module mem16_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // A value of 1 means the current cycle is the one in which target data is valid.
  assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/mem16_master.sv
// mem16 bus initiator: valid/ready commands -> one-cycle sel/wr strobes -> valid/ready responses.
// Optional write readback verification is enabled by defining MEM16_READBACK_EN.
module mem16_master
  import mem16_pkg::*;
#(
  parameter int DW     = MEM16_DW,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [DW-1:0]    cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic             verify_err,
  output logic             bus_sel,
  output logic             bus_wr,
  output logic [DW-1:0]    bus_wdata,
  input  logic [DW-1:0]    bus_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic [ST_W-1:0]  dbg_state
);

  // Handshake rule for both channels: a transfer happens on a rising edge where
  // valid and ready are both 1; the sender holds valid and payload stable until then.

  localparam logic [3:0] LAT = 4'(RD_LAT);

  state_t           r_state;
  logic             r_wr;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic             r_bus_sel;
  logic             r_bus_wr;
  logic [DW-1:0]    r_bus_wdata;
  logic             r_busy;
  logic [CNT_W-1:0] r_txn_count;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_done;

  assign w_cnt_load = ((r_state == ST_ACCESS) && !r_wr) || (r_state == ST_VRD);
  assign w_cnt_dec  = (r_state == ST_WAIT) && !w_cnt_done;

  mem16_lat_cnt u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LAT),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

`ifdef MEM16_READBACK_EN
  logic r_verify_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_verify_err <= 1'b0;
    end else if ((r_state == ST_WAIT) && w_cnt_done && r_wr && (bus_rdata != r_bus_wdata)) begin
      r_verify_err <= 1'b1;
    end
  end

  assign verify_err = r_verify_err;
`else
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr        <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_bus_sel   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_wdata <= '0;
      r_busy      <= 1'b0;
      r_txn_count <= '0;
    end else begin
      // Strobes are one-cycle pulses; only the transitions below raise them.
      r_bus_sel <= 1'b0;
      r_bus_wr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_wr        <= cmd_wr;
            r_txn_count <= r_txn_count + CNT_W'(1);
            r_state     <= ST_ACCESS;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_bus_sel   <= 1'b1;
            r_bus_wr    <= cmd_wr;
            r_bus_wdata <= cmd_wdata;
          end
        end
        ST_ACCESS: begin
          if (r_wr) begin
`ifdef MEM16_READBACK_EN
            r_state   <= ST_VRD;
            r_bus_sel <= 1'b1;
`else
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
`endif
          end else begin
            r_state <= ST_WAIT;
          end
        end
`ifdef MEM16_READBACK_EN
        ST_VRD: begin
          r_state <= ST_WAIT;
        end
`endif
        ST_WAIT: begin
          if (w_cnt_done) begin
            r_rsp_rdata <= bus_rdata;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign bus_sel   = r_bus_sel;
  assign bus_wr    = r_bus_wr;
  assign bus_wdata = r_bus_wdata;
  assign busy      = r_busy;
  assign txn_count = r_txn_count;
  assign dbg_state = r_state;

endmodule
